// File: rtl/fp32_pkg.sv
// Shared binary32 constants and field layout for the FPU datapath.
// Used by the integer-to-float unit and its helpers.
package fp32_pkg;

   localparam int FP32_BIAS   = 127;
   localparam int FP32_EXP_W  = 8;
   localparam int FP32_FRAC_W = 23;

   // Exponent of a value whose leading one sits at bit 31 of the magnitude.
   localparam logic [FP32_EXP_W-1:0] ITOF_EXP_BASE = FP32_EXP_W'(FP32_BIAS + 31);

   typedef struct packed {
      logic                   sign;
      logic [FP32_EXP_W-1:0]  exp;
      logic [FP32_FRAC_W-1:0] frac;
   } fp32_t;

endpackage

// File: rtl/lzc32.sv
// Combinational 32-bit leading-zero counter, built as a log-depth merge tree.
// Returns 32 for an all-zero input.
module lzc32 (
   input  logic [31:0] a,
   output logic [5:0]  cnt
);

   // Each level merges two neighbouring counts: MSB of a count means "all zero".
   logic [1:0] c1 [16];
   logic [2:0] c2 [8];
   logic [3:0] c3 [4];
   logic [4:0] c4 [2];

   for (genvar i = 0; i < 16; i++) begin : g_l1
      assign c1[i] = {~a[2*i+1] & ~a[2*i], ~a[2*i+1] & a[2*i]};
   end

   for (genvar i = 0; i < 8; i++) begin : g_l2
      assign c2[i] = {c1[2*i+1][1] &  c1[2*i][1],
                      c1[2*i+1][1] & ~c1[2*i][1],
                      c1[2*i+1][1] ? c1[2*i][0] : c1[2*i+1][0]};
   end

   for (genvar i = 0; i < 4; i++) begin : g_l3
      assign c3[i] = {c2[2*i+1][2] &  c2[2*i][2],
                      c2[2*i+1][2] & ~c2[2*i][2],
                      c2[2*i+1][2] ? c2[2*i][1:0] : c2[2*i+1][1:0]};
   end

   for (genvar i = 0; i < 2; i++) begin : g_l4
      assign c4[i] = {c3[2*i+1][3] &  c3[2*i][3],
                      c3[2*i+1][3] & ~c3[2*i][3],
                      c3[2*i+1][3] ? c3[2*i][2:0] : c3[2*i+1][2:0]};
   end

   assign cnt = {c4[1][4] &  c4[0][4],
                 c4[1][4] & ~c4[0][4],
                 c4[1][4] ? c4[0][3:0] : c4[1][3:0]};

endmodule

// File: rtl/itof.sv
// Two-stage pipelined int32 -> binary32 converter with round-to-nearest-even.
// Stage 1 takes sign/magnitude and counts leading zeros; stage 2 normalises, rounds, packs.
module itof
   import fp32_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               valid_in,
   input  logic signed [31:0] x,
   output logic               valid_out,
   output logic [31:0]        y
);

   function automatic logic [FP32_FRAC_W:0] round_rne(
      input logic [FP32_FRAC_W-1:0] mant,
      input logic                   guard,
      input logic                   sticky
   );
      logic up;
      up = guard & (sticky | mant[0]);
      return {1'b0, mant} + {{FP32_FRAC_W{1'b0}}, up};
   endfunction

   logic        vld_p1, vld_p2;
   logic        s_p1;
   logic [31:0] m_p1;
   logic [5:0]  lz_p1;
   logic [31:0] y_p2;

   logic [31:0] m_c;
   logic [5:0]  lz_c;

   // Negating 0x80000000 wraps to itself, which is exactly 2^31 unsigned.
   assign m_c = x[31] ? $unsigned(-x) : $unsigned(x);

   lzc32 u_lzc (
      .a   (m_c),
      .cnt (lz_c)
   );

   // ---- stage 1 boundary ----
   always_ff @(posedge clk) begin
      s_p1  <= x[31];
      m_p1  <= m_c;
      lz_p1 <= lz_c;
   end

   logic [31:0]            n_c;
   logic [FP32_FRAC_W:0]   rnd_c;
   logic [FP32_EXP_W-1:0]  e_c;
   fp32_t                  res_c;

   always_comb begin
      n_c   = m_p1 << lz_p1;
      rnd_c = round_rne(n_c[30:8], n_c[7], |n_c[6:0]);
      e_c   = ITOF_EXP_BASE - {2'b00, lz_p1} + {7'd0, rnd_c[FP32_FRAC_W]};
      res_c.sign = s_p1;
      // n[31] clear means the operand was zero: force +0 instead of exponent 126.
      res_c.exp  = n_c[31] ? e_c : '0;
      res_c.frac = rnd_c[FP32_FRAC_W-1:0];
   end

   // ---- stage 2 boundary ----
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p1 <= 1'b0;
         vld_p2 <= 1'b0;
         y_p2   <= '0;
      end else begin
         vld_p1 <= valid_in;
         vld_p2 <= vld_p1;
         if (vld_p1) y_p2 <= res_c;
      end
   end

   assign valid_out = vld_p2;
   assign y         = y_p2;

endmodule

// File: tb/tb_itof.sv
// Bench for itof: directed literal vectors plus an arithmetic reference model
// checked every cycle against valid_out/y.
module tb_itof;

   localparam int NREC = 12000;

   logic               clk = 1'b0;
   logic               rst;
   logic               valid_in;
   logic signed [31:0] x;
   logic               valid_out;
   logic [31:0]        y;

   itof dut (
      .clk       (clk),
      .rst       (rst),
      .valid_in  (valid_in),
      .x         (x),
      .valid_out (valid_out),
      .y         (y)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int vectors     = 0;
   int miscompares = 0;

   bit          rec_v [NREC];
   bit          rec_r [NREC];
   logic [31:0] rec_x [NREC];

   bit          mdl_known = 1'b0;
   bit          mdl_v     = 1'b0;
   logic [31:0] mdl_y     = '0;

   // Reference conversion from value arithmetic: find the power of two,
   // divide down to 24 significant bits, round half to even.
   function automatic logic [31:0] ref_conv(input logic [31:0] xv);
      longint a, p, div, q, r;
      int     e;
      a = longint'($signed(xv));
      if (a < 0) a = -a;
      if (a == 0) return 32'h0;
      p = 1;
      e = 0;
      while (p * 2 <= a) begin
         p = p * 2;
         e++;
      end
      if (e <= 23) begin
         q = a;
         for (int i = e; i < 23; i++) q = q * 2;
      end else begin
         div = p / 64'd8388608;
         q = a / div;
         r = a % div;
         if (2 * r > div || (2 * r == div && (q % 2) == 1)) q = q + 1;
      end
      if (q == 64'd16777216) begin
         q = 64'd8388608;
         e++;
      end
      return {xv[31], 8'(e + 127), 23'(q - 64'd8388608)};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %08h, expected %08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Drive one cycle of inputs (recorded for the model), then move to 1 time unit past the edge.
   task automatic step(input bit v, input logic [31:0] xv, input bit r);
      valid_in = v;
      x        = xv;
      rst      = r;
      if (cyc < NREC) begin
         rec_v[cyc] = v;
         rec_x[cyc] = xv;
         rec_r[cyc] = r;
      end
      @(posedge clk);
      #1;
   endtask

   // Model: inputs driven in cycle k show up after the edge ending cycle k+1,
   // unless a reset edge intervenes; y holds across bubbles and clears on reset.
   always @(negedge clk) begin
      if (cyc >= 2 && cyc < NREC) begin
         if (rec_r[cyc-1]) begin
            mdl_known = 1'b1;
            mdl_v     = 1'b0;
            mdl_y     = '0;
         end else begin
            mdl_v = rec_v[cyc-2] && !rec_r[cyc-2];
            if (mdl_v) mdl_y = ref_conv(rec_x[cyc-2]);
         end
         if (mdl_known) begin
            chk("model_valid", 32'(valid_out), 32'(mdl_v));
            chk("model_y", y, mdl_y);
         end
      end
   end

   logic [31:0] dx [9] = '{32'h00000001, 32'hFFFFFFFF, 32'h00000000,
                           32'h01000001, 32'h01000003, 32'h7FFFFFFF,
                           32'h80000000, 32'h80000001, 32'h00000064};
   logic [31:0] dy [9] = '{32'h3F800000, 32'hBF800000, 32'h00000000,
                           32'h4B800000, 32'h4B800002, 32'h4F000000,
                           32'hCF000000, 32'hCF000000, 32'h42C80000};

   initial begin
      int sel;
      logic [31:0] rx;
      valid_in = 1'b0;
      x        = '0;
      rst      = 1'b1;

      chk("pin_tie_even_down", ref_conv(32'h01000001), 32'h4B800000);
      chk("pin_tie_even_up",   ref_conv(32'h01000003), 32'h4B800002);
      chk("pin_carry",         ref_conv(32'h7FFFFFFF), 32'h4F000000);
      chk("pin_min_int",       ref_conv(32'h80000000), 32'hCF000000);

      step(1'b0, 32'h0, 1'b1);
      step(1'b0, 32'h0, 1'b1);
      chk("reset_valid", 32'(valid_out), 32'h0);
      chk("reset_y", y, 32'h0);
      step(1'b0, 32'h0, 1'b0);

      // Isolated operands: still invalid one edge later, valid exactly at the second edge.
      for (int i = 0; i < 9; i++) begin
         step(1'b1, dx[i], 1'b0);
         chk("lat1_valid", 32'(valid_out), 32'h0);
         step(1'b0, 32'h0, 1'b0);
         chk("dir_valid", 32'(valid_out), 32'h1);
         chk("dir_y", y, dy[i]);
      end

      // Back-to-back stream 1, 2, 3, -4, then one bubble, then 5.
      step(1'b1, 32'd1, 1'b0);
      step(1'b1, 32'd2, 1'b0);
      chk("stream0_v", 32'(valid_out), 32'h1);
      chk("stream0_y", y, 32'h3F800000);
      step(1'b1, 32'd3, 1'b0);
      chk("stream1_v", 32'(valid_out), 32'h1);
      chk("stream1_y", y, 32'h40000000);
      step(1'b1, 32'hFFFFFFFC, 1'b0);
      chk("stream2_v", 32'(valid_out), 32'h1);
      chk("stream2_y", y, 32'h40400000);
      step(1'b0, 32'h0, 1'b0);
      chk("stream3_v", 32'(valid_out), 32'h1);
      chk("stream3_y", y, 32'hC0800000);
      step(1'b1, 32'd5, 1'b0);
      chk("bubble_v", 32'(valid_out), 32'h0);
      chk("bubble_hold_y", y, 32'hC0800000);
      step(1'b0, 32'h0, 1'b0);
      chk("after_bubble_v", 32'(valid_out), 32'h1);
      chk("after_bubble_y", y, 32'h40A00000);

      // Reset with one operand in stage 1 and another at the input.
      step(1'b1, 32'd100, 1'b0);
      step(1'b1, 32'd200, 1'b1);
      chk("rst_flight_v", 32'(valid_out), 32'h0);
      chk("rst_flight_y", y, 32'h0);
      step(1'b0, 32'h0, 1'b0);
      chk("rst_drop_v", 32'(valid_out), 32'h0);
      chk("rst_drop_y", y, 32'h0);
      step(1'b1, 32'd7, 1'b0);
      chk("post_rst_lat_v", 32'(valid_out), 32'h0);
      step(1'b0, 32'h0, 1'b0);
      chk("post_rst_v", 32'(valid_out), 32'h1);
      chk("post_rst_y", y, 32'h40E00000);

      // Random stream with occasional bubbles and forced special values.
      for (int i = 0; i < 10000; i++) begin
         sel = $urandom_range(0, 15);
         case (sel)
            0:       rx = 32'h00000000;
            1:       rx = 32'h80000000;
            2:       rx = 32'h7FFFFFFF;
            3:       rx = 32'($urandom_range(0, 32'h01FFFFFF));
            4:       rx = -32'($urandom_range(0, 32'h01FFFFFF));
            default: rx = $random;
         endcase
         step($urandom_range(0, 7) != 0, rx, 1'b0);
      end

      step(1'b0, 32'h0, 1'b0);
      step(1'b0, 32'h0, 1'b0);
      step(1'b0, 32'h0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
